multdiv_result_latch: RTL and testbench
=======================================

Name: multdiv_result_latch

Overview:
- Return-side counterpart of the multiplier operand latch.
- Tracks one multi-cycle multiply/divide operation from issue until its result is written back.
- Captures the unit's result together with the destination register and instruction, then holds it until the writeback stage grants a slot.
- Generates the RAW stall for the in-flight destination, and a timeout exception if the unit never answers.

Parameters:
- TIMEOUT, 40, cycles in BUSY without result_ready before the op is aborted with exception.
- CNT_W, 6, width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- issue  input  1  one-cycle pulse: op launched into the multdiv unit this cycle.
- reg_input  input  32  destination register number, zero-extended; bits [4:0] used.
- ins_input  input  32  instruction word of the issued op.
- result_in  input  32  result from the multdiv unit.
- result_ready  input  1  result_in valid this cycle.
- exception_in  input  1  unit exception (e.g. divide by zero); sampled with result_ready.
- rs_check  input  5  source register of the instruction in decode.
- rt_check  input  5  second source register of the instruction in decode.
- wb_grant  input  1  writeback accepts wb_* this cycle.
- busy  output  1  state != IDLE.
- stall  output  1  RAW hazard on the in-flight destination.
- wb_valid  output  1  result held and presented.
- wb_data  output  32  held result.
- wb_reg  output  5  held destination.
- wb_ins  output  32  held instruction.
- wb_exception  output  1  held exception flag.

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, every output 0. Reset mid-operation discards the op; a later result_ready is ignored.
- State IDLE: on issue, capture reg_input[4:0] into wb_reg and ins_input into wb_ins, clear counter, go to BUSY (busy=1 the next cycle).
- State BUSY:
  - counter increments each cycle.
  - On result_ready: capture result_in into wb_data and exception_in into wb_exception, go to HOLD. wb_valid=1 the cycle after result_ready (1-cycle latency).
  - If the counter reaches TIMEOUT-1 without result_ready: wb_data=0, wb_exception=1, go to HOLD.
  - result_ready in the same cycle as the timeout: result wins, no timeout exception.
- State HOLD:
  - wb_valid=1; wb_* stable until granted.
  - wb_grant alone: go to IDLE; wb_valid=0 the next cycle.
  - wb_grant and issue in the same cycle: go straight to BUSY with the new op captured; wb_valid=0 the next cycle.
- issue while BUSY, or while HOLD without wb_grant: ignored. Upstream must gate on busy.
- result_ready in IDLE or HOLD: ignored.
- Stall (combinational): stall=1 when state!=IDLE and wb_reg!=0 and (rs_check==wb_reg or rt_check==wb_reg).
  - Exception: stall=0 in HOLD with wb_grant=1, since forwarding is done by writeback.
  - Destination r0 never stalls, but is still written back.
- wb_* outputs in IDLE keep their last values; only wb_valid qualifies them.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, HOLD=2'd2), register-number width 5, word width 32.
- Holding registers reuse the codebase's existing register module (writeEnable driven by the capture conditions).
- One natural sub-module: multdiv_timeout_counter (clear, enable, terminal-count output).

Test Plan:
- Issue reg=5, ins=0x00A52818; result_ready with 0x0000_0030 after 32 cycles; wb_grant held 1 -> wb_valid high exactly 1 cycle later, wb_data=0x30, wb_reg=5, wb_ins=0x00A52818, wb_exception=0; busy for 33 cycles total.
- Op to reg 7 in flight; rs_check=7 -> stall=1 until the grant cycle. rt_check=7 in HOLD with wb_grant=0 -> stall=1. reg 0 in flight with rs_check=0 -> stall=0.
- TIMEOUT=40, no result_ready -> after 40 BUSY cycles: wb_valid=1, wb_data=0, wb_exception=1. A late result_ready while in HOLD leaves wb_data unchanged.
- HOLD with wb_grant=0 for 10 cycles -> wb_* stable; then wb_grant and issue(reg=9) in the same cycle -> next cycle state BUSY, wb_valid=0, wb_reg=9.
- Assert reset asynchronously mid-BUSY (between clock edges) -> busy, stall and wb_valid drop immediately. Following result_ready -> no wb_valid.
- issue during BUSY with reg=3 -> ignored; the original wb_reg is retained and the result is written back once.

Source files
------------

// File: rtl/multdiv_result_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_result_latch_pkg
//  Description : Shared types and widths for the multiply/divide result latch.
//                Holds the tracker state encoding and the register-number and
//                data word widths used by the latch and its sub-blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_result_latch_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/multdiv_result_latch_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_timeout_counter
//  Description : Cycle counter for an in-flight multdiv op. Flags the cycle in
//                which the count equals TIMEOUT-1.
//  Ports       : clock_i    - rising-edge clock
//                reset_i    - asynchronous active-high clear
//                clear_i    - restart the count at zero (priority over enable)
//                enable_i   - advance the count by one
//                terminal_o - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_timeout_counter #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == C_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module      : register
//  Description : Generic enabled holding register with asynchronous clear.
//  Ports       : clock_i        - rising-edge clock
//                reset_i        - asynchronous active-high clear
//                write_enable_i - load d_i on the next rising edge
//                d_i / q_o      - data in / held data out
//  Revision    : 1.0 - initial release
// ============================================================================
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             write_enable_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            q_o <= '0;
        end else if (write_enable_i) begin
            q_o <= d_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multdiv_result_latch.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_result_latch
//  Description : Tracks one multi-cycle multiply/divide op from issue to
//                writeback. Captures destination and instruction at issue,
//                the result (or a timeout exception) at completion, and holds
//                them until writeback grants a slot. Raises a RAW stall for
//                the in-flight destination.
//  Ports       : clock, reset              - clock / async active-high reset
//                issue, reg_input, ins_input - op launch and its dest / instr
//                result_in, result_ready, exception_in - unit return path
//                rs_check, rt_check        - decode-stage source registers
//                wb_grant                  - writeback accepts wb_* this cycle
//                busy, stall               - tracker busy / RAW hazard
//                wb_valid, wb_data, wb_reg, wb_ins, wb_exception - held result
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_result_latch
    import multdiv_result_latch_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue,
    input  logic [WORD_W-1:0] reg_input,
    input  logic [WORD_W-1:0] ins_input,
    input  logic [WORD_W-1:0] result_in,
    input  logic              result_ready,
    input  logic              exception_in,
    input  logic [REG_W-1:0]  rs_check,
    input  logic [REG_W-1:0]  rt_check,
    input  logic              wb_grant,
    output logic              busy,
    output logic              stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg,
    output logic [WORD_W-1:0] wb_ins,
    output logic              wb_exception
);

    state_e            state_q;
    logic              cap_op;
    logic              cap_res;
    logic              cnt_tc;
    logic [WORD_W-1:0] data_d;
    logic              exc_d;
    logic              unused_reg_hi;

    // Only the low five bits of the destination are meaningful.
    assign unused_reg_hi = ^reg_input[WORD_W-1:REG_W];

    // A new op is accepted from IDLE, or from HOLD in the same cycle the
    // held result is granted (back-to-back issue).
    assign cap_op  = issue && ((state_q == ST_IDLE) ||
                               ((state_q == ST_HOLD) && wb_grant));

    // Completion: real result, or timeout. A result arriving in the timeout
    // cycle wins, so no exception is forced then.
    assign cap_res = (state_q == ST_BUSY) && (result_ready || cnt_tc);
    assign data_d  = result_ready ? result_in    : '0;
    assign exc_d   = result_ready ? exception_in : 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (issue) state_q <= ST_BUSY;
                ST_BUSY: if (result_ready || cnt_tc) state_q <= ST_HOLD;
                ST_HOLD: if (wb_grant) state_q <= issue ? ST_BUSY : ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    multdiv_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clock_i    (clock),
        .reset_i    (reset),
        .clear_i    (cap_op),
        .enable_i   (state_q == ST_BUSY),
        .terminal_o (cnt_tc)
    );

    register #(.WIDTH(REG_W)) u_reg_dest (
        .clock_i        (clock),
        .reset_i        (reset),
        .write_enable_i (cap_op),
        .d_i            (reg_input[REG_W-1:0]),
        .q_o            (wb_reg)
    );

    register #(.WIDTH(WORD_W)) u_reg_ins (
        .clock_i        (clock),
        .reset_i        (reset),
        .write_enable_i (cap_op),
        .d_i            (ins_input),
        .q_o            (wb_ins)
    );

    register #(.WIDTH(WORD_W)) u_reg_data (
        .clock_i        (clock),
        .reset_i        (reset),
        .write_enable_i (cap_res),
        .d_i            (data_d),
        .q_o            (wb_data)
    );

    register #(.WIDTH(1)) u_reg_exc (
        .clock_i        (clock),
        .reset_i        (reset),
        .write_enable_i (cap_res),
        .d_i            (exc_d),
        .q_o            (wb_exception)
    );

    assign busy     = (state_q != ST_IDLE);
    assign wb_valid = (state_q == ST_HOLD);

    // r0 never stalls. Once writeback grants the held result it forwards the
    // value itself, so decode need not wait in that cycle.
    always_comb begin
        stall = 1'b0;
        if ((state_q != ST_IDLE) && (wb_reg != '0) &&
            ((rs_check == wb_reg) || (rt_check == wb_reg))) begin
            stall = 1'b1;
        end
        if ((state_q == ST_HOLD) && wb_grant) begin
            stall = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_result_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_result_latch
//  Description : Self-checking bench for multdiv_result_latch: a table of
//                stall scenarios plus directed sequences for latency,
//                timeout, hold/back-to-back issue, async reset and ignored
//                issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_result_latch;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue;
    logic [31:0] reg_input;
    logic [31:0] ins_input;
    logic [31:0] result_in;
    logic        result_ready;
    logic        exception_in;
    logic [4:0]  rs_check;
    logic [4:0]  rt_check;
    logic        wb_grant;
    logic        busy;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic [31:0] wb_ins;
    logic        wb_exception;

    int total  = 0;
    int passed = 0;
    int busy_cycles = 0;
    int wb_accepts  = 0;

    multdiv_result_latch #(.TIMEOUT(40), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue        (issue),
        .reg_input    (reg_input),
        .ins_input    (ins_input),
        .result_in    (result_in),
        .result_ready (result_ready),
        .exception_in (exception_in),
        .rs_check     (rs_check),
        .rt_check     (rt_check),
        .wb_grant     (wb_grant),
        .busy         (busy),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_ins       (wb_ins),
        .wb_exception (wb_exception)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (busy === 1'b1) busy_cycles++;
        if (wb_valid === 1'b1 && wb_grant === 1'b1) wb_accepts++;
    end

    typedef struct {
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       grant;
        logic       exp_busy_stall;
        logic       exp_hold_stall;
    } stall_vec_t;

    stall_vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] r, input logic [31:0] ins);
        issue     = 1'b1;
        reg_input = {27'd0, r};
        ins_input = ins;
        tick();
        issue     = 1'b0;
    endtask

    initial begin
        logic [31:0] d0, i0;
        logic [4:0]  r0;
        logic        changed;

        vecs[0] = '{dest: 5'd7,  rs: 5'd7,  rt: 5'd0,  grant: 1'b0, exp_busy_stall: 1'b1, exp_hold_stall: 1'b1};
        vecs[1] = '{dest: 5'd7,  rs: 5'd0,  rt: 5'd7,  grant: 1'b0, exp_busy_stall: 1'b1, exp_hold_stall: 1'b1};
        vecs[2] = '{dest: 5'd7,  rs: 5'd7,  rt: 5'd3,  grant: 1'b1, exp_busy_stall: 1'b1, exp_hold_stall: 1'b0};
        vecs[3] = '{dest: 5'd0,  rs: 5'd0,  rt: 5'd0,  grant: 1'b0, exp_busy_stall: 1'b0, exp_hold_stall: 1'b0};
        vecs[4] = '{dest: 5'd7,  rs: 5'd6,  rt: 5'd8,  grant: 1'b0, exp_busy_stall: 1'b0, exp_hold_stall: 1'b0};
        vecs[5] = '{dest: 5'd31, rs: 5'd31, rt: 5'd31, grant: 1'b1, exp_busy_stall: 1'b1, exp_hold_stall: 1'b0};
        vecs[6] = '{dest: 5'd12, rs: 5'd1,  rt: 5'd12, grant: 1'b0, exp_busy_stall: 1'b1, exp_hold_stall: 1'b1};

        reset = 1'b1; issue = 1'b0; reg_input = '0; ins_input = '0;
        result_in = '0; result_ready = 1'b0; exception_in = 1'b0;
        rs_check = '0; rt_check = '0; wb_grant = 1'b0;
        tick(); tick();

        // ---------------- reset state ----------------
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset wb_reg", {27'd0, wb_reg}, 32'd0);
        check("reset wb_ins", wb_ins, 32'd0);
        check("reset wb_exception", {31'd0, wb_exception}, 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- basic latency ----------------
        wb_grant = 1'b1;
        busy_cycles = 0;
        do_issue(5'd5, 32'h00A5_2818);
        check("t1 busy after issue", {31'd0, busy}, 32'd1);
        repeat (31) tick();
        check("t1 no valid before result", {31'd0, wb_valid}, 32'd0);
        result_ready = 1'b1; result_in = 32'h30; exception_in = 1'b0;
        tick();
        result_ready = 1'b0;
        check("t1 wb_valid", {31'd0, wb_valid}, 32'd1);
        check("t1 wb_data", wb_data, 32'h30);
        check("t1 wb_reg", {27'd0, wb_reg}, 32'd5);
        check("t1 wb_ins", wb_ins, 32'h00A5_2818);
        check("t1 wb_exception", {31'd0, wb_exception}, 32'd0);
        tick();
        check("t1 wb_valid drops", {31'd0, wb_valid}, 32'd0);
        check("t1 busy drops", {31'd0, busy}, 32'd0);
        check("t1 busy cycles", busy_cycles, 32'd33);
        wb_grant = 1'b0;

        // ---------------- stall table ----------------
        for (int i = 0; i < 7; i++) begin
            do_issue(vecs[i].dest, 32'h1000 + i);
            rs_check = vecs[i].rs;
            rt_check = vecs[i].rt;
            #1;
            check($sformatf("v%0d busy stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_busy_stall});
            tick();
            check($sformatf("v%0d busy stall 2", i), {31'd0, stall}, {31'd0, vecs[i].exp_busy_stall});
            result_ready = 1'b1; result_in = 32'h200 + i;
            tick();
            result_ready = 1'b0;
            wb_grant = vecs[i].grant;
            #1;
            check($sformatf("v%0d hold stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_hold_stall});
            check($sformatf("v%0d hold wb_reg", i), {27'd0, wb_reg}, {27'd0, vecs[i].dest});
            check($sformatf("v%0d hold wb_data", i), wb_data, 32'h200 + i);
            wb_grant = 1'b1;
            tick();
            wb_grant = 1'b0;
            #1;
            check($sformatf("v%0d idle busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d idle stall", i), {31'd0, stall}, 32'd0);
        end
        rs_check = '0; rt_check = '0;

        // ---------------- timeout ----------------
        do_issue(5'd10, 32'hCAFE_0010);
        repeat (39) tick();
        check("to still busy c40", {31'd0, wb_valid}, 32'd0);
        check("to busy c40", {31'd0, busy}, 32'd1);
        tick();
        check("to wb_valid", {31'd0, wb_valid}, 32'd1);
        check("to wb_data", wb_data, 32'd0);
        check("to wb_exception", {31'd0, wb_exception}, 32'd1);
        result_ready = 1'b1; result_in = 32'hDEAD; exception_in = 1'b0;
        tick();
        result_ready = 1'b0;
        check("late result wb_data", wb_data, 32'd0);
        check("late result wb_exception", {31'd0, wb_exception}, 32'd1);

        // ---------------- hold stability, grant+issue ----------------
        d0 = wb_data; r0 = wb_reg; i0 = wb_ins; changed = 1'b0;
        repeat (10) begin
            tick();
            if (wb_data !== d0 || wb_reg !== r0 || wb_ins !== i0 || wb_valid !== 1'b1) changed = 1'b1;
        end
        check("hold stable", {31'd0, changed}, 32'd0);
        wb_grant = 1'b1;
        do_issue(5'd9, 32'h0000_0999);
        wb_grant = 1'b0;
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b wb_valid", {31'd0, wb_valid}, 32'd0);
        check("b2b wb_reg", {27'd0, wb_reg}, 32'd9);
        check("b2b wb_ins", wb_ins, 32'h0000_0999);

        // result in the timeout cycle wins
        repeat (39) tick();
        result_ready = 1'b1; result_in = 32'h55; exception_in = 1'b0;
        tick();
        result_ready = 1'b0;
        check("tc result wb_valid", {31'd0, wb_valid}, 32'd1);
        check("tc result wb_data", wb_data, 32'h55);
        check("tc result wb_exception", {31'd0, wb_exception}, 32'd0);
        wb_grant = 1'b1;
        tick();
        wb_grant = 1'b0;

        // exception_in passthrough
        do_issue(5'd2, 32'h0000_0002);
        result_ready = 1'b1; result_in = 32'h77; exception_in = 1'b1;
        tick();
        result_ready = 1'b0; exception_in = 1'b0;
        check("unit exc wb_exception", {31'd0, wb_exception}, 32'd1);
        check("unit exc wb_data", wb_data, 32'h77);
        wb_grant = 1'b1;
        tick();
        wb_grant = 1'b0;

        // ---------------- async reset mid-BUSY ----------------
        do_issue(5'd4, 32'h0000_0004);
        repeat (3) tick();
        rs_check = 5'd4;
        #1;
        check("ar stall before", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar busy", {31'd0, busy}, 32'd0);
        check("ar stall", {31'd0, stall}, 32'd0);
        check("ar wb_valid", {31'd0, wb_valid}, 32'd0);
        reset = 1'b0;
        rs_check = '0;
        tick();
        result_ready = 1'b1; result_in = 32'h99;
        tick();
        result_ready = 1'b0;
        check("ar late result no valid", {31'd0, wb_valid}, 32'd0);
        tick();
        check("ar late result no valid 2", {31'd0, wb_valid}, 32'd0);

        // ---------------- issue during BUSY ignored ----------------
        wb_accepts = 0;
        do_issue(5'd6, 32'hAAAA_0006);
        repeat (2) tick();
        do_issue(5'd3, 32'hBBBB_0003);
        check("ib wb_reg kept", {27'd0, wb_reg}, 32'd6);
        check("ib wb_ins kept", wb_ins, 32'hAAAA_0006);
        result_ready = 1'b1; result_in = 32'h66;
        tick();
        result_ready = 1'b0;
        check("ib wb_valid", {31'd0, wb_valid}, 32'd1);
        check("ib wb_reg", {27'd0, wb_reg}, 32'd6);
        wb_grant = 1'b1;
        tick();
        check("ib wb_valid drops", {31'd0, wb_valid}, 32'd0);
        repeat (3) tick();
        wb_grant = 1'b0;
        check("ib single writeback", wb_accepts, 32'd1);
        check("ib idle after", {31'd0, busy}, 32'd0);

        // result_ready in IDLE ignored
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("idle result ignored", {31'd0, wb_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
